// File: rtl/branch_resolve_if.sv
// branch_resolve_if: execute-to-fetch branch request and PC/redirect/flush bus
//   master: drives br_valid, br_op, br_rs, br_rt, br_pc, br_offset, pc_advance
//   slave : drives br_ready, pc, redirect, flush, stall, taken_count
interface branch_resolve_if #(parameter int WIDTH = 16);
  logic             br_valid;
  logic             br_ready;
  logic [1:0]       br_op;
  logic [WIDTH-1:0] br_rs;
  logic [WIDTH-1:0] br_rt;
  logic [WIDTH-1:0] br_pc;
  logic [WIDTH-1:0] br_offset;
  logic             pc_advance;
  logic [WIDTH-1:0] pc;
  logic             redirect;
  logic             flush;
  logic             stall;
  logic [7:0]       taken_count;
  modport master(
    output br_valid, br_op, br_rs, br_rt, br_pc, br_offset, pc_advance,
    input  br_ready, pc, redirect, flush, stall, taken_count
  );
  modport slave(
    input  br_valid, br_op, br_rs, br_rt, br_pc, br_offset, pc_advance,
    output br_ready, pc, redirect, flush, stall, taken_count
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves branches, owns the fetch PC, drives redirect/flush
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : branch request in (valid/ready, op, rs, rt, pc, offset), pc_advance in;
//                pc, redirect, flush, stall, taken_count out
module branch_resolve_unit #(
  parameter int               WIDTH        = 16,
  parameter int               FLUSH_CYCLES = 2,
  parameter logic [WIDTH-1:0] RESET_PC     = '0
) (
  input logic              clk,
  input logic              rst_n,
  branch_resolve_if.slave  bus
);
  localparam int CW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, RESOLVE, FLUSH} state_t;
  state_t           state_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] rs_q, rt_q, bpc_q, off_q, pc_q, pc_d, target_d;
  logic             taken_d, redirect_q, flush_q;
  logic [CW-1:0]    cnt_q;
  logic [7:0]       taken_count_q;
  always_comb begin
    taken_d  = op_q == 2'b00 ? rs_q == rt_q :
               op_q == 2'b01 ? rs_q != rt_q :
               op_q == 2'b10 ? rs_q != '0 : 1'b1;
    target_d = bpc_q + WIDTH'(1) + off_q;
    // a redirect load beats pc_advance; pc_advance is ignored while flushing
    pc_d     = (state_q == RESOLVE && taken_d) ? target_d :
               (bus.pc_advance && state_q != FLUSH) ? pc_q + WIDTH'(1) : pc_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      redirect_q    <= 1'b0;
      flush_q       <= 1'b0;
      cnt_q         <= '0;
      taken_count_q <= '0;
      op_q          <= '0;
      rs_q          <= '0;
      rt_q          <= '0;
      bpc_q         <= '0;
      off_q         <= '0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        IDLE: if (bus.br_valid) begin
          op_q    <= bus.br_op;
          rs_q    <= bus.br_rs;
          rt_q    <= bus.br_rt;
          bpc_q   <= bus.br_pc;
          off_q   <= bus.br_offset;
          state_q <= RESOLVE;
        end
        RESOLVE: if (taken_d) begin
          redirect_q    <= 1'b1;
          flush_q       <= 1'b1;
          cnt_q         <= CW'(FLUSH_CYCLES - 1);
          taken_count_q <= taken_count_q + {7'd0, taken_count_q != 8'hFF};
          state_q       <= FLUSH;
        end else begin
          state_q <= IDLE;
        end
        FLUSH: begin
          redirect_q <= 1'b0;
          if (cnt_q == '0) begin
            flush_q <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.br_ready    = state_q == IDLE;
  assign bus.stall       = state_q != IDLE;
  assign bus.pc          = pc_q;
  assign bus.redirect    = redirect_q;
  assign bus.flush       = flush_q;
  assign bus.taken_count = taken_count_q;
endmodule
